switch_debounce_3: RTL and testbench



---
 rtl/switch_debounce_3_pkg.sv | 15 +
 rtl/switch_debounce_3_debounce_bit.sv | 55 +++++
 rtl/switch_debounce_3.sv | 55 +++++
 tb/tb_switch_debounce_3.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_3_pkg.sv
// Shared constants for the three-channel switch debouncer.
//   N_SW                  : number of independent switch channels
//   DEF_STABLE_CYCLES     : default count of consecutive differing cycles
//                           needed before a channel output flips
//   DEF_CNT_W             : default width of each per-channel counter
//   ZERO_VEC              : reset value of the debounced vector
package switch_debounce_3_pkg;

  localparam int N_SW              = 3;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 16;

  localparam logic [N_SW-1:0] ZERO_VEC = '0;

endpackage

// File: rtl/switch_debounce_3_debounce_bit.sv
// One debounced switch channel.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high reset
//   raw     : asynchronous switch level
//   out     : debounced, synchronised level (registered)
//   update  : high in the cycle before out flips; out takes the new value
//             on the next rising edge (combinational from registers)
//   eq      : synchronised level equals out, nothing pending
module debounce_bit #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic out,
  output logic update,
  output logic eq
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Terminal count reached while the synchronised level still differs:
  // the next edge commits the new level.
  assign eq     = (s2 == out);
  assign update = !eq && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      // Two-flop synchroniser; only s1 ever looks at raw.
      s1 <= raw;
      s2 <= s1;
      if (eq) begin
        cnt <= '0;
      end else if (update) begin
        // Cleared at terminal count, so the counter never wraps.
        out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debounce_3.sv
// Three-channel switch input conditioner feeding the 3-input AND block.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high reset
//   raw     : three asynchronous switch levels, independent channels
//   out     : debounced, synchronised vector (registered)
//   changed : one-cycle pulse in the cycle out first shows a new value
//   stable  : every synchronised bit equals its out bit
//
// Output protocol: changed acts as a valid strobe for out. It is high for
// exactly the cycle(s) in which out differs from its previous value; there
// is no ready, the consumer must sample out while changed is high. Several
// bits flipping on one edge give one pulse; flips on consecutive edges give
// back-to-back pulses.
module switch_debounce_3
  import switch_debounce_3_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] raw,
  output logic [N_SW-1:0] out,
  output logic            changed,
  output logic            stable
);

  logic [N_SW-1:0] update;
  logic [N_SW-1:0] eq;

  for (genvar b = 0; b < N_SW; b++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw[b]),
      .out    (out[b]),
      .update (update[b]),
      .eq     (eq[b])
    );
  end

  // update[] looks one edge ahead, so registering its OR lines the pulse up
  // with the cycle in which out shows the new value.
  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else       changed <= |update;
  end

  assign stable = &eq;

endmodule

// File: tb/tb_switch_debounce_3.sv
module tb_switch_debounce_3;

  logic       clk;
  logic       reset;
  logic [2:0] raw;
  logic [2:0] out;
  logic       changed;
  logic       stable;
  logic       and_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Each entry: {edge number on which out changes, expected out}
  logic [34:0] exp_q[$];

  switch_debounce_3 dut (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw),
    .out     (out),
    .changed (changed),
    .stable  (stable)
  );

  // Downstream 3-input AND block.
  assign and_out = &out;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_change(input int edge_no, input logic [2:0] v);
    exp_q.push_back({32'(edge_no), v});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_changed at edge %0d: out=%b, no change expected", cyc, out);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (e[34:3] !== 32'(cyc)) begin
          n_fail++;
          $display("FAIL change_edge: changed at edge %0d expected edge %0d", cyc, e[34:3]);
        end
        check3("change_value", out, e[2:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    reset = 1'b1;
    raw   = 3'b000;

    // 1. reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check3("rst_out", out, 3'b000);
      check3("rst_changed", 3'(changed), 3'b000);
      check3("rst_stable", 3'(stable), 3'b001);
    end
    reset = 1'b0;
    tick(2);
    check3("post_rst_out", out, 3'b000);
    check3("post_rst_stable", 3'(stable), 3'b001);
    check3("post_rst_and", 3'(and_out), 3'b000);

    // 2. 000 -> 101
    c = cyc;
    raw = 3'b101;
    expect_change(c + 6, 3'b101);
    tick(1);
    check3("t2_stable_e1", 3'(stable), 3'b001);
    tick(1);
    check3("t2_stable_e2", 3'(stable), 3'b000);
    tick(3);
    check3("t2_out_e5", out, 3'b000);
    check3("t2_stable_e5", 3'(stable), 3'b000);
    tick(1);
    check3("t2_out_e6", out, 3'b101);
    check3("t2_changed_e6", 3'(changed), 3'b001);
    check3("t2_stable_e6", 3'(stable), 3'b001);
    check3("t2_and_e6", 3'(and_out), 3'b000);
    tick(1);
    check3("t2_changed_e7", 3'(changed), 3'b000);

    // 3. -> 111, AND goes high with out
    c = cyc;
    raw = 3'b111;
    expect_change(c + 6, 3'b111);
    tick(5);
    check3("t3_and_e5", 3'(and_out), 3'b000);
    tick(1);
    check3("t3_out_e6", out, 3'b111);
    check3("t3_and_e6", 3'(and_out), 3'b001);
    tick(2);

    // back to 000
    c = cyc;
    raw = 3'b000;
    expect_change(c + 6, 3'b000);
    tick(8);
    check3("t3_return", out, 3'b000);

    // 4a. 3-cycle glitch on bit 0: rejected
    raw = 3'b001;
    tick(3);
    raw = 3'b000;
    tick(10);
    check3("t4_glitch3_out", out, 3'b000);
    check3("t4_glitch3_stable", 3'(stable), 3'b001);

    // 4b. 4-cycle pulse: accepted, held 4 cycles, then released
    c = cyc;
    raw = 3'b001;
    expect_change(c + 6, 3'b001);
    expect_change(c + 10, 3'b000);
    tick(4);
    raw = 3'b000;
    tick(2);
    check3("t4_pulse_e6", out, 3'b001);
    tick(3);
    check3("t4_pulse_e9", out, 3'b001);
    tick(1);
    check3("t4_pulse_e10", out, 3'b000);
    tick(3);

    // 5. staggered: raw[2] then raw[0] two cycles later
    c = cyc;
    raw = 3'b100;
    expect_change(c + 6, 3'b100);
    expect_change(c + 8, 3'b101);
    tick(2);
    raw = 3'b101;
    tick(4);
    check3("t5_e6", out, 3'b100);
    tick(1);
    check3("t5_changed_e7", 3'(changed), 3'b000);
    tick(1);
    check3("t5_e8", out, 3'b101);
    tick(2);
    c = cyc;
    raw = 3'b000;
    expect_change(c + 6, 3'b000);
    tick(8);

    // 6. reset in the middle of a pending 010
    c = cyc;
    raw = 3'b010;
    tick(3);
    reset = 1'b1;
    tick(1);
    check3("t6_rst_out", out, 3'b000);
    check3("t6_rst_stable", 3'(stable), 3'b001);
    reset = 1'b0;
    expect_change(c + 10, 3'b010);
    tick(5);
    check3("t6_out_e9", out, 3'b000);
    tick(1);
    check3("t6_out_e10", out, 3'b010);
    check3("t6_changed_e10", 3'(changed), 3'b001);
    tick(4);

    // every expected change must have been observed
    check3("queue_drained", (exp_q.size() == 0) ? 3'b001 : 3'b000, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
